// File: rtl/dcim_pkg.sv
// Shared types and constants for the DCIM input sequencer.
// Holds the FSM state enum, default widths and the bit-index width helper.
package dcim_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } seq_state_e;

    localparam int ACC_W_DEF   = 51;
    localparam int IN_BITS_DEF = 8;
    localparam int BIDX_W_DEF  = $clog2(IN_BITS_DEF);

    // Width of a counter that indexes n bit-planes; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dcim_out_buf.sv
// Result storage behind the sequencer: one register, or a 2-entry FIFO when
// DCIM_OUT_BUF_EN is defined. space_o already counts a pop in the same cycle.
module dcim_out_buf #(
    parameter int W = 51
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_ready_i,
    output logic         space_o,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

`ifdef DCIM_OUT_BUF_EN
    logic [W-1:0] mem_q [2];
    logic         wptr_q;
    logic         rptr_q;
    logic [1:0]   cnt_q;
    logic         pop;
    logic         push_ok;

    assign pop     = (cnt_q != 2'd0) && pop_ready_i;
    assign space_o = (cnt_q != 2'd2) || pop;
    assign push_ok = push_i && space_o;
    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = mem_q[rptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
            cnt_q <= cnt_q + {1'b0, push_ok} - {1'b0, pop};
        end
    end
`else
    logic         valid_q;
    logic [W-1:0] data_q;
    logic         pop;

    assign pop     = valid_q && pop_ready_i;
    assign space_o = !valid_q || pop_ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (push_i && space_o) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/dcim_input_sequencer.sv
// Streams an input vector to the DCIM macro as MSB-first bit-planes, drives the
// accumulator clear (st) and captures its result. DCIM_OUT_BUF_EN selects a 2-deep result FIFO.
module dcim_input_sequencer
    import dcim_pkg::*;
#(
    parameter int ROWS    = 64,
    parameter int IN_BITS = IN_BITS_DEF,
    parameter int PS_LAT  = 0,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*IN_BITS-1:0] in_data,
    output logic [ROWS-1:0]         plane,
    output logic                    plane_en,
    output logic                    st,
    input  logic [ACC_W-1:0]        acc_nout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic                    busy
);

    localparam int BIDX_W = idx_width(IN_BITS);
    localparam int DR_W   = 3;

    seq_state_e         state_q;
    logic [BIDX_W-1:0]  bit_q;
    logic [DR_W-1:0]    drain_q;
    logic [IN_BITS-1:0] rows_q [ROWS];
    logic [IN_BITS-1:0] row_in [ROWS];
    logic [ROWS-1:0]    plane_load;
    logic [ROWS-1:0]    plane_shift;
    logic [ROWS-1:0]    plane_q;
    logic               plane_en_q;
    logic               en_d;
    logic               buf_space;
    logic               accept;
    logic               capture;

    // Each row is a left shifter; its MSB is always the next plane bit to send.
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            assign row_in[gi]      = in_data[gi*IN_BITS +: IN_BITS];
            assign plane_load[gi]  = row_in[gi][IN_BITS-1];
            assign plane_shift[gi] = rows_q[gi][IN_BITS-1];
        end
    endgenerate

    assign in_ready = (state_q == IDLE) && buf_space && !rst;
    assign accept   = in_valid && in_ready;
    assign capture  = (state_q == DRAIN) && (drain_q == '0);
    assign busy     = (state_q != IDLE);
    assign plane    = plane_q;
    assign plane_en = plane_en_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            drain_q    <= '0;
            plane_q    <= '0;
            plane_en_q <= 1'b0;
            for (int r = 0; r < ROWS; r++) rows_q[r] <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= STREAM;
                        bit_q      <= BIDX_W'(IN_BITS - 1);
                        plane_q    <= plane_load;
                        plane_en_q <= 1'b1;
                        for (int r = 0; r < ROWS; r++) rows_q[r] <= row_in[r] << 1;
                    end
                end
                STREAM: begin
                    if (bit_q == '0) begin
                        state_q    <= DRAIN;
                        drain_q    <= DR_W'(PS_LAT);
                        plane_q    <= '0;
                        plane_en_q <= 1'b0;
                    end else begin
                        bit_q   <= bit_q - 1'b1;
                        plane_q <= plane_shift;
                        for (int r = 0; r < ROWS; r++) rows_q[r] <= rows_q[r] << 1;
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) state_q <= IDLE;
                    else               drain_q <= drain_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // en_d lines st up with the partial sum arriving PS_LAT cycles after its plane.
    generate
        if (PS_LAT == 0) begin : g_no_dly
            assign en_d = plane_en_q;
        end else begin : g_dly
            logic [PS_LAT-1:0] dly_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) dly_q <= '0;
                else     dly_q <= (dly_q << 1) | PS_LAT'(plane_en_q);
            end
            assign en_d = dly_q[PS_LAT-1];
        end
    endgenerate

    assign st = ~en_d;

    dcim_out_buf #(
        .W (ACC_W)
    ) u_out_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (capture),
        .data_i      (acc_nout),
        .pop_ready_i (out_ready),
        .space_o     (buf_space),
        .valid_o     (out_valid),
        .data_o      (out_data)
    );

endmodule

// File: tb/tb_dcim_input_sequencer.sv
// Directed bench for dcim_input_sequencer: two instances (PS_LAT=0 and 2), each
// driving a popcount macro model and a shift-add accumulator controlled by st.
module tb_dcim_input_sequencer;

    localparam int ROWS = 64;
    localparam int IB   = 8;
    localparam int DW   = ROWS * IB;
    localparam int AW   = 51;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          in_valid0 = 1'b0, in_ready0, plane_en0, st0, out_valid0, out_ready0 = 1'b1, busy0;
    logic [DW-1:0] in_data0 = '0;
    logic [ROWS-1:0] plane0;
    logic [AW-1:0] acc0 = '0, out_data0;

    logic          in_valid2 = 1'b0, in_ready2, plane_en2, st2, out_valid2, out_ready2 = 1'b1, busy2;
    logic [DW-1:0] in_data2 = '0;
    logic [ROWS-1:0] plane2;
    logic [AW-1:0] acc2 = '0, out_data2;
    logic [6:0]    ps2_p1 = '0, ps2_p2 = '0;

    dcim_input_sequencer #(.ROWS(ROWS), .IN_BITS(IB), .PS_LAT(0), .ACC_W(AW)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .plane(plane0), .plane_en(plane_en0), .st(st0), .acc_nout(acc0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .busy(busy0)
    );

    dcim_input_sequencer #(.ROWS(ROWS), .IN_BITS(IB), .PS_LAT(2), .ACC_W(AW)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .plane(plane2), .plane_en(plane_en2), .st(st2), .acc_nout(acc2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .busy(busy2)
    );

    // Macro + accumulator models: partial sum = popcount(plane), acc = (acc<<1)+ps unless st.
    always @(posedge clk) begin
        acc0   <= st0 ? '0 : (acc0 << 1) + AW'($countones(plane0));
        ps2_p1 <= 7'($countones(plane2));
        ps2_p2 <= ps2_p1;
        acc2   <= st2 ? '0 : (acc2 << 1) + AW'(ps2_p2);
    end

    int   n_tests = 0;
    int   n_fail  = 0;
    logic en_hist [64];
    logic p0_hist [64];
    logic st_hist [64];

    function automatic logic [DW-1:0] fill(input logic [7:0] v);
        logic [DW-1:0] d;
        for (int r = 0; r < ROWS; r++) d[r*IB +: IB] = v;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input bit sel, input logic [DW-1:0] d, output int t_acc);
        t_acc = -1;
        if (sel) begin in_valid2 = 1'b1; in_data2 = d; end
        else     begin in_valid0 = 1'b1; in_data0 = d; end
        for (int i = 0; i < 100; i++) begin
            if ((sel ? in_ready2 : in_ready0) === 1'b1) begin
                tick();
                t_acc = cyc;
                break;
            end
            tick();
        end
        if (sel) in_valid2 = 1'b0;
        else     in_valid0 = 1'b0;
    endtask

    task automatic wait_res(input bit sel, input int t_acc, output int lat, output logic [AW-1:0] data);
        lat  = -1;
        data = '0;
        for (int i = 0; i < 64; i++) begin
            en_hist[i] = sel ? plane_en2 : plane_en0;
            p0_hist[i] = sel ? plane2[0] : plane0[0];
            st_hist[i] = sel ? st2 : st0;
            if ((sel ? out_valid2 : out_valid0) === 1'b1) begin
                lat  = cyc - t_acc;
                data = sel ? out_data2 : out_data0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_tests++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready0); end
        n_tests++; if (st0 !== 1'b1) begin n_fail++; $display("FAIL rst_st: got %b expected 1", st0); end
        n_tests++; if (plane_en0 !== 1'b0) begin n_fail++; $display("FAIL rst_plane_en: got %b expected 0", plane_en0); end
        n_tests++; if (plane0 !== '0) begin n_fail++; $display("FAIL rst_plane: got %h expected 0", plane0); end
        n_tests++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid0); end
        n_tests++; if (out_data0 !== '0) begin n_fail++; $display("FAIL rst_out_data: got %0d expected 0", out_data0); end
        n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy0); end
        n_tests++; if (st2 !== 1'b1) begin n_fail++; $display("FAIL rst_st_lat2: got %b expected 1", st2); end
        rst = 1'b0;
        #1;
        n_tests++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready0); end
        tick();
        $display("[TB] reset checks done");
    endtask

    task automatic test_all_ones();
        int t, lat;
        logic [AW-1:0] d;
        out_ready0 = 1'b1;
        offer(1'b0, fill(8'hFF), t);
        wait_res(1'b0, t, lat, d);
        n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL ones_latency: got %0d expected 9", lat); end
        n_tests++; if (d !== AW'(16320)) begin n_fail++; $display("FAIL ones_data: got %0d expected 16320", d); end
        $display("[TB] all-ones vector: result %0d latency %0d", d, lat);
        tick();
    endtask

    task automatic test_msb_only();
        int t, lat;
        logic [AW-1:0] d;
        logic [DW-1:0] v;
        logic [8:0] en_pat;
        logic [7:0] p0_pat;
        v = '0;
        v[IB-1:0] = 8'h80;
        offer(1'b0, v, t);
        wait_res(1'b0, t, lat, d);
        for (int i = 0; i < 9; i++) en_pat[i] = en_hist[i];
        for (int i = 0; i < 8; i++) p0_pat[i] = p0_hist[i];
        n_tests++; if (en_pat !== 9'b0_1111_1111) begin n_fail++; $display("FAIL msb_plane_en_pattern: got %b expected 011111111", en_pat); end
        n_tests++; if (p0_pat !== 8'b0000_0001) begin n_fail++; $display("FAIL msb_plane0_pattern: got %b expected 00000001", p0_pat); end
        n_tests++; if (d !== AW'(128)) begin n_fail++; $display("FAIL msb_data: got %0d expected 128", d); end
        n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL msb_latency: got %0d expected 9", lat); end
        $display("[TB] row0=0x80 vector: result %0d plane_en %b", d, en_pat);
        tick();
    endtask

    task automatic test_pslat2();
        int t, lat, low_cnt, first_low;
        logic [AW-1:0] d;
        out_ready2 = 1'b1;
        offer(1'b1, fill(8'h01), t);
        wait_res(1'b1, t, lat, d);
        low_cnt   = 0;
        first_low = -1;
        for (int i = 0; i < 64; i++) begin
            if (i <= lat && st_hist[i] === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = i + 1;
            end
        end
        n_tests++; if (low_cnt !== 8) begin n_fail++; $display("FAIL lat2_st_low_cycles: got %0d expected 8", low_cnt); end
        n_tests++; if (first_low !== 3) begin n_fail++; $display("FAIL lat2_st_first_low: got %0d expected 3", first_low); end
        n_tests++; if (d !== AW'(64)) begin n_fail++; $display("FAIL lat2_data: got %0d expected 64", d); end
        n_tests++; if (lat !== 11) begin n_fail++; $display("FAIL lat2_latency: got %0d expected 11", lat); end
        $display("[TB] PS_LAT=2 vector: result %0d latency %0d", d, lat);
        tick();
    endtask

    task automatic test_backpressure();
        int t, lat, hold_bad;
        bit got;
        logic [AW-1:0] d;
        out_ready0 = 1'b0;
        offer(1'b0, fill(8'h01), t);
        wait_res(1'b0, t, lat, d);
        n_tests++; if (d !== AW'(64)) begin n_fail++; $display("FAIL bp_first_data: got %0d expected 64", d); end
        in_valid0 = 1'b1;
        in_data0  = fill(8'h02);
        got       = 1'b0;
        hold_bad  = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid0 !== 1'b1 || out_data0 !== AW'(64)) hold_bad++;
            if (in_ready0 === 1'b1) got = 1'b1;
            tick();
            if (got) in_valid0 = 1'b0;
        end
        n_tests++; if (hold_bad !== 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d bad cycles expected 0", hold_bad); end
`ifdef DCIM_OUT_BUF_EN
        n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL bp_fifo_accept: got %b expected 1", got); end
        out_ready0 = 1'b1;
        #1;
        n_tests++; if (out_data0 !== AW'(64)) begin n_fail++; $display("FAIL bp_fifo_first: got %0d expected 64", out_data0); end
        tick();
        n_tests++; if (out_valid0 !== 1'b1 || out_data0 !== AW'(128)) begin n_fail++; $display("FAIL bp_fifo_second: got valid %b data %0d expected valid 1 data 128", out_valid0, out_data0); end
        tick();
        n_tests++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL bp_fifo_empty: got %b expected 0", out_valid0); end
        $display("[TB] back-pressure with FIFO: both results delivered in order");
`else
        n_tests++; if (got !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_held: got %b expected 0", got); end
        out_ready0 = 1'b1;
        #1;
        n_tests++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready0); end
        offer(1'b0, fill(8'h02), t);
        wait_res(1'b0, t, lat, d);
        n_tests++; if (d !== AW'(128)) begin n_fail++; $display("FAIL bp_second_data: got %0d expected 128", d); end
        $display("[TB] back-pressure single register: second result %0d", d);
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        int t, lat, spurious;
        logic [AW-1:0] d;
        out_ready0 = 1'b1;
        offer(1'b0, fill(8'hFF), t);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_tests++; if (plane_en0 !== 1'b0) begin n_fail++; $display("FAIL midrst_plane_en: got %b expected 0", plane_en0); end
        n_tests++; if (st0 !== 1'b1) begin n_fail++; $display("FAIL midrst_st: got %b expected 1", st0); end
        n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy0); end
        tick();
        rst = 1'b0;
        spurious = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid0 !== 1'b0) spurious++;
            tick();
        end
        n_tests++; if (spurious !== 0) begin n_fail++; $display("FAIL midrst_no_out_valid: got %0d cycles expected 0", spurious); end
        offer(1'b0, fill(8'h03), t);
        wait_res(1'b0, t, lat, d);
        n_tests++; if (d !== AW'(192)) begin n_fail++; $display("FAIL midrst_next_data: got %0d expected 192", d); end
        $display("[TB] reset mid-stream then 0x03 vector: result %0d", d);
        tick();
    endtask

    task automatic test_back_to_back();
        int t1, t2, lat;
        logic [AW-1:0] d;
        out_ready0 = 1'b1;
        offer(1'b0, fill(8'h11), t1);
        offer(1'b0, fill(8'h05), t2);
        n_tests++; if (t2 - t1 !== 10) begin n_fail++; $display("FAIL b2b_interval: got %0d expected 10", t2 - t1); end
        wait_res(1'b0, t2, lat, d);
        n_tests++; if (d !== AW'(320)) begin n_fail++; $display("FAIL b2b_second_data: got %0d expected 320", d); end
        $display("[TB] back-to-back: interval %0d second result %0d", t2 - t1, d);
        tick();
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_msb_only();
        test_pslat2();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
